bin_to_bcd_seq: RTL and testbench

//  Sequential (shift-add-3 / double-dabble) binary-to-BCD converter: one bit per clock.

---
 rtl/fnd_pkg.sv | 10 +
 rtl/bcd_add3.sv | 11 +
 rtl/bin_to_bcd_seq.sv | 94 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared FND/BCD definitions for the display path.
package fnd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam int         BCD_NIB     = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] BCD_NINE    = 4'h9;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 when the nibble is 5 or more.
module bcd_add3
    import fnd_pkg::*;
(
    input  logic [BCD_NIB-1:0] nib_i,
    output logic [BCD_NIB-1:0] nib_o
);

    assign nib_o = (nib_i >= ADD3_THRESH) ? nib_i + BCD_NIB'(3) : nib_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative shift-add-3 binary-to-BCD converter, one bit per clock, saturating at all nines.
module bin_to_bcd_seq
    import fnd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset_p,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_NIB*DIGITS-1:0] bcd,
    output logic                      overflow
);

    localparam int SCR_W = BCD_NIB * (DIGITS + 1);
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_e                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_d;
    logic [BIN_W-1:0]            bin_sr_q;
    logic [SCR_W-1:0]            scr_q;
    logic [SCR_W-1:0]            scr_d;
    logic [SCR_W-1:0]            adj;
    logic                        busy_q;
    logic                        done_q;
    logic                        ovf_q;
    logic                        ovf_d;
    logic [BCD_NIB*DIGITS-1:0]   bcd_q;
    logic [BCD_NIB*DIGITS-1:0]   bcd_d;

    for (genvar g = 0; g <= DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i(scr_q[g*BCD_NIB +: BCD_NIB]),
            .nib_o(adj[g*BCD_NIB +: BCD_NIB])
        );
    end

    // A bit pushed out of the guard nibble also means the value cannot fit.
    assign scr_d = {adj[SCR_W-2:0], bin_sr_q[BIN_W-1]};
    assign cnt_d = cnt_q - 1'b1;
    assign ovf_d = adj[SCR_W-1] | (|scr_d[SCR_W-1 -: BCD_NIB]);
    assign bcd_d = ovf_d ? {DIGITS{BCD_NINE}} : scr_d[BCD_NIB*DIGITS-1:0];

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bin_sr_q <= '0;
            scr_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            bcd_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_sr_q <= bin;
                        scr_q    <= '0;
                        cnt_q    <= CNT_W'(BIN_W);
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    scr_q    <= scr_d;
                    bin_sr_q <= bin_sr_q << 1;
                    cnt_q    <= cnt_d;
                    // Results are taken from the final shift so they land with done.
                    if (cnt_d == '0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bcd_q   <= bcd_d;
                        ovf_q   <= ovf_d;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench; driver queues expected results, monitor checks each done pulse.
module tb_bin_to_bcd_seq;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_p;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   prev_done = 0;
    bit   have_prev = 0;
    bit   sweep_mode = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   vals[$];

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk(clk),
        .reset_p(reset_p),
        .start(start),
        .bin(bin),
        .busy(busy),
        .done(done),
        .bcd(bcd),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int v);
        exp_t e;
        if (v > 9999) begin
            e.bcd = 16'h9999;
            e.ovf = 1'b1;
        end else begin
            e.bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic conv(input int v);
        @(negedge clk);
        start = 1'b1;
        bin   = 14'(v);
        sb.push_back(model(v));
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            chk("busy_window", {30'd0, done, busy}, 32'b01);
        end
        @(negedge clk);
        chk("done_cycle", {30'd0, done, busy}, 32'b10);
    endtask

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done bcd %0h overflow %0b at cycle %0d", bcd, overflow, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("bcd", 32'(bcd), 32'(mon_e.bcd));
                chk("overflow", 32'(overflow), 32'(mon_e.ovf));
            end
            if (sweep_mode) begin
                if (have_prev) chk("done_spacing", cyc - prev_done, 16);
                prev_done = cyc;
                have_prev = 1'b1;
            end
        end
        if (!sweep_mode) have_prev = 1'b0;
    end

    initial begin
        int dc;
        reset_p = 1'b1;
        start   = 1'b0;
        bin     = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {13'd0, busy, done, overflow, bcd}, 32'd0);
        reset_p = 1'b0;

        conv(0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);

        conv(9999);
        repeat (5) @(negedge clk);
        chk("bcd_hold", 32'(bcd), 32'h9999);

        dc = done_cnt;
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd1234;
        sb.push_back(model(1234));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        bin   = 14'd5678;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("ignored_start_dones", done_cnt - dc, 1);

        conv(12000);
        repeat (3) @(negedge clk);
        chk("overflow_hold", 32'(overflow), 32'd1);
        conv(59);

        @(negedge clk);
        start = 1'b1;
        bin   = 14'd4321;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        reset_p = 1'b1;
        @(negedge clk);
        chk("abort_state", {14'd0, busy, done, bcd}, 32'd0);
        reset_p = 1'b0;
        dc = done_cnt;
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt - dc, 0);
        conv(60);

        for (int v = 1; v <= 20; v++) vals.push_back(v);
        vals.push_back(0);
        vals.push_back(9999);
        vals.push_back(10000);
        vals.push_back(16383);
        for (int i = 0; i < 3000; i++) vals.push_back(int'($urandom_range(0, 16383)));
        @(negedge clk);
        sweep_mode = 1'b1;
        start = 1'b1;
        bin   = 14'(vals[0]);
        sb.push_back(model(vals[0]));
        for (int k = 0; k < vals.size(); k++) begin
            @(posedge clk);
            #1;
            if (k == vals.size() - 1) begin
                start = 1'b0;
            end else begin
                repeat (15) @(posedge clk);
                #1 bin = 14'(vals[k+1]);
                sb.push_back(model(vals[k+1]));
            end
        end
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        chk("sweep_drain", sb.size(), 0);
        sweep_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
